// File: rtl/vector_compare_mask.sv
// Element-serial vector compare stage: compares A/B element pairs and emits {valid, bit}
// results plus the write-start pulse for mask_vector. Define VCMP_SIGNED_EN for signed ops.
module vector_compare_mask #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned VALID      = 1,
  parameter int unsigned MVL        = 16,
  localparam int unsigned VlrW      = $clog2(MVL + 1) + 1,
  localparam int unsigned CntW      = $clog2(MVL + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [VlrW-1:0]             VLR,
  input  logic [2:0]                  op,
  input  logic                        use_scalar,
  input  logic [DATA_WIDTH-1:0]       scalar_b,
  input  logic [DATA_WIDTH+VALID-1:0] operand_a,
  input  logic [DATA_WIDTH+VALID-1:0] operand_b,
  output logic                        operand_ready,
  output logic                        w_signal,
  output logic [1:0]                  mask_o,
  output logic                        busy,
  output logic                        done
);

  typedef enum logic [1:0] {StIdle, StArm, StRun, StFlush} state_e;

  state_e                state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [CntW-1:0]       vlr_q, vlr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  use_scalar_q, use_scalar_d;
  logic [DATA_WIDTH-1:0] scalar_q, scalar_d;
  logic                  mask_valid_q, mask_valid_d;
  logic                  mask_bit_q, mask_bit_d;
  logic                  done_q, done_d;

  logic [DATA_WIDTH-1:0] a_data, b_data;
  logic                  a_vld, b_vld, accept;
  logic                  eq, ltu, lt_sel, cmp_res;
  logic [CntW-1:0]       vlr_sat, cnt_inc;

  assign a_data = operand_a[DATA_WIDTH-1:0];
  assign a_vld  = operand_a[DATA_WIDTH];
  assign b_vld  = operand_b[DATA_WIDTH];
  assign b_data = use_scalar_q ? scalar_q : operand_b[DATA_WIDTH-1:0];

  assign eq  = (a_data == b_data);
  assign ltu = (a_data < b_data);

`ifdef VCMP_SIGNED_EN
  assign lt_sel = ($signed(a_data) < $signed(b_data));
`else
  // Signed predicates collapse onto the unsigned comparator.
  assign lt_sel = ltu;
`endif

  always_comb begin
    cmp_res = 1'b0;
    unique case (op_q)
      3'b000: cmp_res = eq;
      3'b001: cmp_res = ~eq;
      3'b010: cmp_res = lt_sel;
      3'b011: cmp_res = lt_sel | eq;
      3'b100: cmp_res = ltu;
      3'b101: cmp_res = ltu | eq;
      3'b110: cmp_res = ~(lt_sel | eq);
      3'b111: cmp_res = ~(ltu | eq);
    endcase
  end

  assign vlr_sat = (VLR > VlrW'(MVL)) ? CntW'(MVL) : VLR[CntW-1:0];
  assign cnt_inc = cnt_q + CntW'(1);
  assign accept  = (state_q == StRun) && a_vld && (use_scalar_q || b_vld);

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    vlr_d        = vlr_q;
    cnt_d        = cnt_q;
    use_scalar_d = use_scalar_q;
    scalar_d     = scalar_q;
    mask_valid_d = 1'b0;
    mask_bit_d   = mask_bit_q;
    done_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (VLR == '0) begin
            // Zero-length request completes here; mask_vector is never armed.
            done_d = 1'b1;
          end else begin
            op_d         = op;
            vlr_d        = vlr_sat;
            use_scalar_d = use_scalar;
            scalar_d     = scalar_b;
            cnt_d        = '0;
            state_d      = StArm;
          end
        end
      end
      StArm: begin
        state_d = StRun;
      end
      StRun: begin
        if (accept) begin
          mask_valid_d = 1'b1;
          mask_bit_d   = cmp_res;
          cnt_d        = cnt_inc;
          if (cnt_inc == vlr_q) begin
            state_d = StFlush;
            done_d  = 1'b1;
          end
        end
      end
      StFlush: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      op_q         <= '0;
      vlr_q        <= '0;
      cnt_q        <= '0;
      use_scalar_q <= 1'b0;
      scalar_q     <= '0;
      mask_valid_q <= 1'b0;
      mask_bit_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      vlr_q        <= vlr_d;
      cnt_q        <= cnt_d;
      use_scalar_q <= use_scalar_d;
      scalar_q     <= scalar_d;
      mask_valid_q <= mask_valid_d;
      mask_bit_q   <= mask_bit_d;
      done_q       <= done_d;
    end
  end

  assign operand_ready = (state_q == StRun);
  assign w_signal      = (state_q == StArm);
  assign busy          = (state_q != StIdle);
  assign mask_o        = {mask_valid_q, mask_bit_q};
  assign done          = done_q;

endmodule

// File: tb/tb_vector_compare_mask.sv
// Directed bench for vector_compare_mask: a predicate model fills an expected-result queue
// that a negedge compare process drains; per-cycle handshake/timing checks run in the driver.
module tb_vector_compare_mask;
  localparam int DW  = 32;
  localparam int MVL = 16;
  localparam int VW  = $clog2(MVL + 1) + 1;

  logic          clk = 1'b0;
  logic          rst, start, use_scalar;
  logic [VW-1:0] vlr;
  logic [2:0]    op;
  logic [DW-1:0] scalar_b;
  logic [DW:0]   operand_a, operand_b;
  logic          operand_ready, w_signal, busy, done;
  logic [1:0]    mask_o;

  vector_compare_mask #(.DATA_WIDTH(DW), .VALID(1), .MVL(MVL)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .VLR           (vlr),
    .op            (op),
    .use_scalar    (use_scalar),
    .scalar_b      (scalar_b),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .operand_ready (operand_ready),
    .w_signal      (w_signal),
    .mask_o        (mask_o),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            n_vec = 0;
  int            n_miss = 0;
  logic          exp_q[$];
  logic          exp_bit;
  int            got_cnt = 0;
  logic [31:0]   res_bits;
  logic [DW-1:0] va[MVL];
  logic [DW-1:0] vb[MVL];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic pred(input logic [2:0] o, input logic [DW-1:0] a,
                                input logic [DW-1:0] b);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
`ifndef VCMP_SIGNED_EN
    sa = ua;
    sb = ub;
`endif
    case (o)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd2:    return sa < sb;
      3'd3:    return sa <= sb;
      3'd4:    return ua < ub;
      3'd5:    return ua <= ub;
      3'd6:    return sa > sb;
      default: return ua > ub;
    endcase
  endfunction

  always @(negedge clk) begin
    if (mask_o[1]) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        exp_bit = exp_q.pop_front();
        chk("result_bit", mask_o[0], exp_bit);
        if (got_cnt < 32) res_bits[got_cnt] = mask_o[0];
        got_cnt++;
      end
    end
  end

  task automatic chk_all_zero(input string name);
    chk(name, {w_signal, mask_o, operand_ready, busy, done}, 0);
  endtask

  // bub: bit k set => k-th RUN cycle presents no valid pair. abort: reset after that many
  // accepts. poke: RUN-cycle index at which a stray start is pulsed.
  task automatic run_vec(input int n, input logic [2:0] o, input logic us, input logic [DW-1:0] sc,
                         input int bub, input int abort, input int poke, input int exp_done);
    int   nsat = (n > MVL) ? MVL : n;
    int   idx = 0, k = 0, n0, rel;
    logic rdy = 1'b0, pres = 1'b0, last_acc = 1'b0, fin = 1'b0;
    for (int i = 0; i < nsat; i++)
      if (abort == 0 || i < abort) exp_q.push_back(pred(o, va[i], us ? sc : vb[i]));
    got_cnt    = 0;
    res_bits   = '0;
    start      = 1'b1;
    vlr        = n[VW-1:0];
    op         = o;
    use_scalar = us;
    scalar_b   = sc;
    @(posedge clk);
    #1;
    n0         = cyc;
    start      = 1'b0;
    vlr        = 6'd1;
    op         = ~o;
    scalar_b   = ~sc;
    use_scalar = ~us;
    for (int t = 0; t < 200 && !fin; t++) begin
      pres      = (idx < nsat) && (((bub >> k) & 1) == 0);
      operand_a = {pres, va[idx % MVL]};
      operand_b = {pres && !us, vb[idx % MVL]};
      if (poke >= 0 && k == poke) begin
        start = 1'b1;
        vlr   = 6'd2;
        op    = 3'b000;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      rel = cyc - n0 + 1;
      rdy = operand_ready;
      chk("w_signal", w_signal, (rel == 1) && (nsat > 0));
      chk("busy", busy, nsat > 0);
      if (rel == 1) chk("ready_in_arm", operand_ready, 0);
      if (rel == 2 && nsat > 0) chk("ready_rise", operand_ready, 1);
      chk("mask_valid", mask_o[1], last_acc);
      if (nsat == 0) chk("done_zero_vlr", done, rel == 1);
      else chk("done", done, last_acc && (idx == nsat));
      if (done) begin
        if (exp_done >= 0) chk("done_cycle", rel, exp_done);
        fin = 1'b1;
      end
      @(posedge clk);
      last_acc = rdy && pres;
      if (last_acc) idx++;
      if (rdy) k++;
      #1;
      if (!fin && abort > 0 && idx == abort) begin
        rst       = 1'b1;
        operand_a = '0;
        operand_b = '0;
        start     = 1'b0;
        @(negedge clk);
        chk("pre_reset_result", mask_o[1], 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("after_reset");
        fin = 1'b1;
      end
    end
    if (!fin) chk("timeout", 0, 1);
    start     = 1'b0;
    operand_a = '0;
    operand_b = '0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("result_count", got_cnt, (abort > 0) ? abort : nsat);
    chk("queue_empty", exp_q.size(), 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    vlr        = '0;
    op         = '0;
    use_scalar = 1'b0;
    scalar_b   = '0;
    operand_a  = '0;
    operand_b  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset_state");
    @(posedge clk);
    #1;
    rst = 1'b0;

    chk("pin_eq", pred(3'd0, 32'd7, 32'd7), 1);
    chk("pin_ne", pred(3'd1, 32'd3, 32'd3), 0);
    chk("pin_leu", pred(3'd5, 32'd7, 32'd7), 1);
`ifdef VCMP_SIGNED_EN
    chk("pin_gt_signed", pred(3'd6, 32'h8000_0000, 32'd1), 0);
`else
    chk("pin_gt_signed", pred(3'd6, 32'h8000_0000, 32'd1), 1);
`endif

    // EQ, vector/vector, continuous: results 1,0,1,0
    va[0] = 1; va[1] = 2; va[2] = 3; va[3] = 4;
    vb[0] = 1; vb[1] = 0; vb[2] = 3; vb[3] = 9;
    run_vec(4, 3'b000, 1'b0, '0, 0, 0, -1, 6);
    chk("eq_bits", res_bits[3:0], 4'b0101);

    // LT signed against scalar 0
    va[0] = 32'hFFFF_FFFF; va[1] = 5; va[2] = 0;
    run_vec(3, 3'b010, 1'b1, 32'd0, 0, 0, -1, 5);
`ifdef VCMP_SIGNED_EN
    chk("lt_scalar_bits", res_bits[2:0], 3'b001);
`else
    chk("lt_scalar_bits", res_bits[2:0], 3'b000);
`endif

    // GTU with bubbles on RUN cycles 2 and 4: results 1,0,1,0,1
    va[0] = 10; va[1] = 3; va[2] = 32'h8000_0000; va[3] = 7; va[4] = 7;
    vb[0] = 5;  vb[1] = 9; vb[2] = 1;             vb[3] = 7; vb[4] = 6;
    run_vec(5, 3'b111, 1'b0, '0, 32'b10100, 0, -1, 9);
    chk("gtu_bits", res_bits[4:0], 5'b10101);

    // Zero-length request
    run_vec(0, 3'b000, 1'b0, '0, 0, 0, -1, 1);

    // Reset after 2 of 8, then a normal VLR=2 run
    for (int i = 0; i < MVL; i++) begin
      va[i] = $urandom_range(0, 7);
      vb[i] = $urandom_range(0, 7);
    end
    run_vec(8, 3'b100, 1'b0, '0, 0, 2, -1, -1);
    run_vec(2, 3'b001, 1'b0, '0, 0, 0, -1, 4);

    // VLR=MVL with LE signed and a stray start during RUN
    for (int i = 0; i < MVL; i++) begin
      va[i] = $urandom();
      vb[i] = (i % 3 == 0) ? va[i] : $urandom();
    end
    run_vec(16, 3'b011, 1'b0, '0, 0, 0, 3, 18);

    // Over-length VLR saturates to MVL
    run_vec(20, 3'b101, 1'b0, '0, 0, 0, -1, 18);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
